// File: rtl/rnn_bist_sequencer.sv
// On-chip stimulus/response sequencer for the RNN tile: drives LFSR or external
// vectors, folds each settled response into a MISR and flags pass/fail at the end.
module rnn_bist_sequencer #(
  parameter int                DATA_W     = 8,
  parameter int                NUM_VEC    = 16,
  parameter int                SETTLE     = 2,
  parameter logic [DATA_W-1:0] POLY       = 8'hB8,
  parameter logic [DATA_W-1:0] SEED       = 8'h01,
  parameter int                SIG_W      = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY   = 16'h8016,
  parameter logic [SIG_W-1:0]  SIG_EXPECT = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] ext_in,
  input  logic [DATA_W-1:0] dut_out,
  output logic [DATA_W-1:0] dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   settle_cnt;
  logic [IDX_W-1:0]   vec_idx;
  logic [DATA_W-1:0]  lfsr;
  logic [DATA_W-1:0]  lfsr_next;
  logic [SIG_W-1:0]   sig_next;
  logic               mode_q;
  logic               pass_q;
  logic               settle_end;
  logic               last_vec;
  logic               start_run;
  logic               do_capture;

  assign lfsr_next  = {lfsr[DATA_W-2:0], ^(lfsr & POLY)};
  assign sig_next   = {signature[SIG_W-2:0], ^(signature & SIG_POLY)} ^ SIG_W'(dut_out);
  assign settle_end = (settle_cnt == CNT_W'(SETTLE - 1));
  assign last_vec   = (vec_idx == IDX_W'(NUM_VEC - 1));
  assign pass       = pass_q;

  // ena low freezes the whole machine, which makes resumption cycle-exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (ena) begin
      // NOTE: sequential state always uses <= so every register samples pre-edge values.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    state_next = state;
    unique case (state)
      S_IDLE:    if (start) state_next = S_SETTLE;
      S_SETTLE:  if (settle_end) state_next = S_CAPTURE;
      S_CAPTURE: state_next = last_vec ? S_DONE : S_SETTLE;
      S_DONE:    if (start) state_next = S_SETTLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    start_run  = 1'b0;
    do_capture = 1'b0;
    unique case (state)
      S_IDLE:    start_run = start;
      S_SETTLE:  busy = 1'b1;
      S_CAPTURE: begin
        busy       = 1'b1;
        do_capture = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        start_run = start;
      end
      default: ;
    endcase
  end

  // Datapath: stimulus generation, settle timing and response compaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in     <= '0;
      lfsr       <= SEED;
      vec_idx    <= '0;
      settle_cnt <= '0;
      signature  <= '0;
      pass_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else if (ena) begin
      if (start_run) begin
        mode_q     <= mode;
        signature  <= '0;
        vec_idx    <= '0;
        settle_cnt <= '0;
        pass_q     <= 1'b0;
        lfsr       <= SEED;
        dut_in     <= mode ? ext_in : SEED;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_end ? '0 : settle_cnt + 1'b1;
      end else if (do_capture) begin
        signature <= sig_next;
        lfsr      <= lfsr_next;
        vec_idx   <= vec_idx + 1'b1;
        if (!last_vec) begin
          dut_in <= mode_q ? ext_in : lfsr_next;
        end else begin
          // The final vector stays on the bus while DONE holds.
          pass_q <= (sig_next == SIG_EXPECT);
        end
      end
    end
  end

endmodule

// File: tb/tb_rnn_bist_sequencer.sv
// Self-checking bench for rnn_bist_sequencer: randomized runs against a
// vector-list / signature-fold reference model.
module tb_rnn_bist_sequencer;

  localparam int              S        = 2;
  localparam int              N        = 16;
  localparam int              NB       = 4;
  localparam logic [7:0]      SEED     = 8'h01;
  localparam logic [7:0]      POLY     = 8'hB8;
  localparam logic [15:0]     SIG_POLY = 16'h8016;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ena_a, start_a, mode_a, loop_a;
  logic [7:0]  ext_a, resp_drv_a, dout_a, din_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] sig_a;

  logic        ena_b, start_b, mode_b;
  logic [7:0]  ext_b, din_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] sig_b;

  assign dout_a = loop_a ? din_a : resp_drv_a;

  rnn_bist_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .start(start_a), .mode(mode_a),
    .ext_in(ext_a), .dut_out(dout_a), .dut_in(din_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  rnn_bist_sequencer #(.NUM_VEC(NB), .SETTLE(S)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .start(start_b), .mode(mode_b),
    .ext_in(ext_b), .dut_out(din_b), .dut_in(din_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  ext_v  [N];
  logic [7:0]  resp_v [N];
  logic [7:0]  exp_v  [N];
  logic [15:0] exp_sig[N+1];

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    logic fb = 1'b0;
    for (int i = 0; i < 8; i++) if (x[i] && POLY[i]) fb = ~fb;
    return {x[6:0], fb};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
    logic fb = 1'b0;
    for (int i = 0; i < 16; i++) if (s[i] && SIG_POLY[i]) fb = ~fb;
    return {s[14:0], fb} ^ {8'h00, d};
  endfunction

  // Expected vector list and running signature after each capture.
  task automatic build_model(input bit md, input bit loop);
    exp_sig[0] = '0;
    for (int i = 0; i < N; i++) begin
      if (md) exp_v[i] = ext_v[i];
      else if (i == 0) exp_v[i] = SEED;
      else exp_v[i] = lfsr_step(exp_v[i-1]);
      exp_sig[i+1] = misr_step(exp_sig[i], loop ? exp_v[i] : resp_v[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_vectors();
    for (int i = 0; i < N; i++) begin
      ext_v[i]  = 8'($urandom);
      resp_v[i] = 8'($urandom);
    end
  endtask

  // One full run on DUT A; edges are counted in ena-high cycles after the start edge.
  task automatic run_a(input bit md, input bit loop, input int gate_at, input int gate_len,
                       input bit noise, input int abort_at);
    int          t_end;
    int          cur;
    logic [7:0]  h_din;
    logic [15:0] h_sig;
    logic [2:0]  h_flags;
    t_end = N * (S + 1);
    build_model(md, loop);
    loop_a = loop; ena_a = 1'b1; mode_a = md; ext_a = ext_v[0]; resp_drv_a = resp_v[0];
    start_a = 1'b1;
    tick();
    start_a = 1'b0; mode_a = 1'($urandom);
    n_tests++;
    if ({din_a, busy_a, done_a, pass_a, sig_a} !== {exp_v[0], 3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL start_edge: got din=%h busy=%b done=%b pass=%b sig=%h, want din=%h busy=1 done=0 pass=0 sig=0000",
               din_a, busy_a, done_a, pass_a, sig_a, exp_v[0]);
    end
    for (int e = 1; e <= t_end; e++) begin
      if (e == gate_at) begin
        ena_a = 1'b0; h_din = din_a; h_sig = sig_a; h_flags = {busy_a, done_a, pass_a};
        for (int g = 0; g < gate_len; g++) begin
          start_a = 1'($urandom); ext_a = 8'($urandom); resp_drv_a = 8'($urandom);
          tick();
          n_tests++;
          if ({din_a, sig_a, busy_a, done_a, pass_a} !== {h_din, h_sig, h_flags}) begin
            n_fail++;
            $display("FAIL ena_hold: got din=%h sig=%h flags=%b, want din=%h sig=%h flags=%b",
                     din_a, sig_a, {busy_a, done_a, pass_a}, h_din, h_sig, h_flags);
          end
        end
        ena_a = 1'b1;
      end
      ext_a = (e % (S + 1) == 0 && e / (S + 1) < N) ? ext_v[e / (S + 1)] : 8'($urandom);
      resp_drv_a = resp_v[(e - 1) / (S + 1)];
      start_a = noise ? 1'($urandom) : 1'b0;
      tick();
      start_a = 1'b0;
      if (e == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({din_a, busy_a, done_a, pass_a, sig_a} !== '0) begin
          n_fail++;
          $display("FAIL async_reset: got din=%h busy=%b done=%b pass=%b sig=%h, want all zero",
                   din_a, busy_a, done_a, pass_a, sig_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({din_a, busy_a, done_a, pass_a, sig_a} !== '0) begin
          n_fail++;
          $display("FAIL post_reset_idle: got din=%h busy=%b done=%b pass=%b sig=%h, want all zero",
                   din_a, busy_a, done_a, pass_a, sig_a);
        end
        return;
      end
      cur = (e < t_end) ? e / (S + 1) : N - 1;
      n_tests++;
      if ({din_a, busy_a, done_a} !== {exp_v[cur], e < t_end, e == t_end}) begin
        n_fail++;
        $display("FAIL run_edge%0d: got din=%h busy=%b done=%b, want din=%h busy=%b done=%b",
                 e, din_a, busy_a, done_a, exp_v[cur], e < t_end, e == t_end);
      end
      n_tests++;
      if (sig_a !== exp_sig[e / (S + 1)]) begin
        n_fail++;
        $display("FAIL signature_edge%0d: got %h, want %h", e, sig_a, exp_sig[e / (S + 1)]);
      end
      if (e == t_end) begin
        n_tests++;
        if (pass_a !== (exp_sig[N] == 16'h0000)) begin
          n_fail++;
          $display("FAIL pass_flag: got %b, want %b", pass_a, exp_sig[N] == 16'h0000);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      ext_a = 8'($urandom); resp_drv_a = 8'($urandom);
      tick();
      n_tests++;
      if ({din_a, busy_a, done_a, pass_a, sig_a} !== {exp_v[N-1], 2'b01, exp_sig[N] == 16'h0000, exp_sig[N]}) begin
        n_fail++;
        $display("FAIL done_hold: got din=%h busy=%b done=%b pass=%b sig=%h, want din=%h busy=0 done=1 sig=%h",
                 din_a, busy_a, done_a, pass_a, sig_a, exp_v[N-1], exp_sig[N]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ena_a = 1'($urandom); start_a = 1'($urandom); mode_a = 1'($urandom);
      ext_a = 8'($urandom); resp_drv_a = 8'($urandom); loop_a = 1'($urandom);
      tick();
      n_tests++;
      if ({din_a, busy_a, done_a, pass_a, sig_a} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: got din=%h busy=%b done=%b pass=%b sig=%h, want all zero",
                 din_a, busy_a, done_a, pass_a, sig_a);
      end
    end
    start_a = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ena_a = 1'($urandom); mode_a = 1'($urandom); ext_a = 8'($urandom); resp_drv_a = 8'($urandom);
      tick();
      n_tests++;
      if ({din_a, busy_a, done_a, pass_a, sig_a} !== '0) begin
        n_fail++;
        $display("FAIL idle_after_reset: got din=%h busy=%b done=%b pass=%b sig=%h, want all zero",
                 din_a, busy_a, done_a, pass_a, sig_a);
      end
    end
  endtask

  task automatic test_lfsr_loop();
    randomize_vectors();
    run_a(1'b0, 1'b1, -1, 0, 1'b0, -1);
  endtask

  task automatic test_zero_response();
    for (int i = 0; i < N; i++) resp_v[i] = 8'h00;
    run_a(1'b0, 1'b0, -1, 0, 1'b0, -1);
    n_tests++;
    if ({sig_a, pass_a} !== {16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_resp: got sig=%h pass=%b, want sig=0000 pass=1", sig_a, pass_a);
    end
    resp_v[N-1] = 8'h01;
    run_a(1'b0, 1'b0, -1, 0, 1'b0, -1);
    n_tests++;
    if ({sig_a, pass_a} !== {16'h0001, 1'b0}) begin
      n_fail++;
      $display("FAIL last_resp_01: got sig=%h pass=%b, want sig=0001 pass=0", sig_a, pass_a);
    end
  endtask

  task automatic test_ext_random();
    for (int r = 0; r < 2; r++) begin
      randomize_vectors();
      run_a(1'b1, 1'b0, -1, 0, 1'b1, -1);
    end
  endtask

  task automatic test_ena_gating();
    logic [15:0] ref_sig;
    randomize_vectors();
    run_a(1'b0, 1'b0, -1, 0, 1'b0, -1);
    ref_sig = sig_a;
    run_a(1'b0, 1'b0, 10, 5, 1'b0, -1);
    n_tests++;
    if (sig_a !== ref_sig) begin
      n_fail++;
      $display("FAIL gated_signature: got %h, want %h", sig_a, ref_sig);
    end
  endtask

  task automatic test_reset_midrun();
    randomize_vectors();
    run_a(1'b1, 1'b0, -1, 0, 1'b0, 7 * (S + 1) + 1);
    run_a(1'b1, 1'b0, -1, 0, 1'b0, -1);
  endtask

  // Small external-mode run on DUT B, with mid-run start pulses and a start on the DONE edge.
  task automatic test_back_to_back();
    logic [7:0]  tab[NB];
    logic [15:0] want_sig;
    int          t_end;
    tab[0] = 8'hA5; tab[1] = 8'h5A; tab[2] = 8'hFF; tab[3] = 8'h00;
    want_sig = '0;
    for (int i = 0; i < NB; i++) want_sig = misr_step(want_sig, tab[i]);
    t_end = NB * (S + 1);
    ena_b = 1'b1; mode_b = 1'b1; ext_b = tab[0]; start_b = 1'b1;
    tick();
    start_b = 1'b0; mode_b = 1'b0;
    n_tests++;
    if ({din_b, busy_b, done_b} !== {tab[0], 2'b10}) begin
      n_fail++;
      $display("FAIL b_start: got din=%h busy=%b done=%b, want din=%h busy=1 done=0", din_b, busy_b, done_b, tab[0]);
    end
    for (int e = 1; e <= t_end; e++) begin
      ext_b = (e % (S + 1) == 0 && e < t_end) ? tab[e / (S + 1)] : 8'($urandom);
      start_b = (e == t_end) ? 1'b1 : 1'($urandom);
      tick();
      n_tests++;
      if ({din_b, busy_b, done_b} !== {tab[(e < t_end) ? e / (S + 1) : NB - 1], e < t_end, e == t_end}) begin
        n_fail++;
        $display("FAIL b_edge%0d: got din=%h busy=%b done=%b, want din=%h busy=%b done=%b", e, din_b, busy_b,
                 done_b, tab[(e < t_end) ? e / (S + 1) : NB - 1], e < t_end, e == t_end);
      end
    end
    n_tests++;
    if ({sig_b, pass_b} !== {want_sig, want_sig == 16'h0000}) begin
      n_fail++;
      $display("FAIL b_signature: got sig=%h pass=%b, want sig=%h pass=%b", sig_b, pass_b, want_sig, want_sig == 16'h0000);
    end
    mode_b = 1'b1; ext_b = tab[0];
    tick();
    start_b = 1'b0;
    n_tests++;
    if ({din_b, busy_b, done_b, pass_b, sig_b} !== {tab[0], 3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL b_restart: got din=%h busy=%b done=%b pass=%b sig=%h, want din=%h busy=1 done=0 pass=0 sig=0000",
               din_b, busy_b, done_b, pass_b, sig_b, tab[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ena_a = 1'b0; start_a = 1'b0; mode_a = 1'b0; loop_a = 1'b0; ext_a = '0; resp_drv_a = '0;
    ena_b = 1'b0; start_b = 1'b0; mode_b = 1'b0; ext_b = '0;
    @(negedge clk);
    test_reset();
    test_lfsr_loop();
    test_zero_response();
    test_ext_random();
    test_ena_gating();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
